shifter_operand_unit: RTL and testbench
=======================================

// Module: shifter_operand_unit
// PURPOSE
//  Next-generation shifter-operand / offset generator between decode and ALU/address adder.
//  Width is parametrised. Adds a valid/ready handshake with a registered output.
//  Adds register-specified shifts, ARM-exact carry-out (including RRX), and a multi-cycle
//  LDM/STM register-list scan.
// PARAMETERS
//  DATA_W      32  operand width; power of 2, >=16; IR stays 32 bits
//  SCAN_LANES  4   IR[15:0] bits popcounted per cycle in LDM/STM scan; divides 16
//  BR_ADJ      4   constant added to scaled branch offset
// PORTS
//  CLK              in   1       single clock, rising edge
//  RST_N            in   1       asynchronous active-low reset
//  IN_VALID         in   1       command valid
//  IN_READY         out  1       command accepted when IN_VALID&&IN_READY at CLK edge
//  IR               in   32      instruction word
//  RM               in   DATA_W  Rm operand
//  RS               in   DATA_W  Rs operand (amount = RS[7:0])
//  CIN              in   1       current C flag
//  ENABLE           in   1       0: bypass (operand=RM, carry=CIN)
//  OUT_VALID        out  1       result valid; held until OUT_READY
//  OUT_READY        in   1       consumer ready
//  SHIFTER_OPERAND  out  DATA_W  result
//  COUT             out  1       shifter carry-out
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE, OUT_VALID=0, SHIFTER_OPERAND=0, COUT=0, IN_READY=0 while low.
//  Reset mid-scan or mid-hold aborts the command; no result is produced.
//  States:
//   IDLE: accepts when IN_READY. Single-cycle ops go to HOLD with the result registered;
//         latency 1, OUT_VALID rises the cycle after acceptance.
//   SCAN: LDM/STM only; 16/SCAN_LANES cycles accumulating popcount; then HOLD.
//   HOLD: OUT_VALID=1, outputs stable. On OUT_READY: to IDLE, or directly accepts the next command.
//  IN_READY = state!=SCAN && (!OUT_VALID || OUT_READY)  (back-to-back throughput 1/cycle).
//  Decode (ENABLE=1, on IR[27:25]); sh=IR[6:5] (LSL,LSR,ASR,ROR), imm5=IR[11:7]:
//   001       imm8 ROR 2*IR[11:8] within DATA_W; C = rot==0 ? CIN : result[DATA_W-1]
//   000 IR4=0 Rm shift imm5:
//             LSL#0 -> Rm, C=CIN
//             LSR#0 -> 0, C=Rm[msb]
//             ASR#0 -> all Rm[msb], C=Rm[msb]
//             ROR#0 -> RRX {CIN,Rm>>1}, C=Rm[0]
//             otherwise standard shift, C = last bit shifted out
//   000 IR4=1 IR7=0  Rm shift RS[7:0] (n):
//             n==0 -> Rm, C=CIN
//             LSL/LSR: n==DATA_W -> 0, C=Rm[0]/Rm[msb]; n>DATA_W -> 0, C=0
//             ASR: n>=DATA_W -> all Rm[msb], C=Rm[msb]
//             ROR: n%DATA_W==0 -> Rm, C=Rm[msb]; otherwise rotate by n%DATA_W
//   000 IR4=1 IR7=1  zero-extended {IR[11:8],IR[3:0]}, C=CIN
//   010       zero-extended IR[11:0], C=CIN
//   011       identical to 000/IR4=0 (scaled register offset)
//   100       4*popcount(IR[15:0]) zero-extended (scan), C=CIN; empty list -> 0
//   101       (sext(IR[23:0])<<2) + BR_ADJ, truncated to DATA_W, C=CIN
//   11x       RM, C=CIN
//  ENABLE=0: RM, C=CIN, single-cycle path regardless of IR.
//  Inputs are sampled only at acceptance; IN_VALID/IR changes during SCAN/HOLD are ignored.
// CONFIGURATION
//  SHIFTER_REG_SHIFT_EN defined: register-specified shifts as above.
//  SHIFTER_REG_SHIFT_EN undefined: 000/IR4=1/IR7=0 returns RM, C=CIN; RS unused.
//  Timing is identical in both builds.
// STRUCTURE
//  shifter_pkg: shift-type constants LSL/LSR/ASR/ROR, IR[27:25] class constants,
//   FSM state encoding (IDLE/SCAN/HOLD).
//  Sub-module shifter_barrel (combinational): data, amount, type, rrx, cin -> result, carry.
//   Instanced once; the top holds the FSM, scan counter, and output registers.
// TESTING
//  1. IR=0x0000_0000, RM=0x8000_0001, OUT_READY=1 -> one cycle later operand 0x8000_0001, C=CIN.
//  2. IR[27:25]=001, imm8=0xFF, rot=4 -> 0xFF00_0000, C=1; rot=0, CIN=1 -> 0x0000_00FF, C=1.
//  3. ROR#0 (RRX), RM=0x0000_0003, CIN=1 -> 0x8000_0001, C=1.
//     LSR#0, RM=0x8000_0000 -> 0, C=1.
//  4. Register LSL, RS=32, RM=0x1 -> 0, C=1; RS=33 -> 0, C=0.
//     Register ROR, RS=64 -> RM, C=RM[31].
//  5. LDM IR[15:0]=0xFFFF -> after 4 SCAN cycles + HOLD, 0x40; IN_READY=0 throughout SCAN.
//     IR[15:0]=0 -> 0.
//  6. OUT_READY held 0 for 3 cycles -> result stable, IN_READY=0.
//     Assert RST_N=0 mid-SCAN -> OUT_VALID=0 immediately, IDLE after release.

Source files
------------

// File: rtl/shifter_pkg.sv
// shifter_pkg: shift types, IR[27:25] instruction classes and FSM states
// shared by shifter_operand_unit and shifter_barrel.
package shifter_pkg;
  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;
  localparam logic [2:0] CLS_SHIFT  = 3'b000;
  localparam logic [2:0] CLS_IMM    = 3'b001;
  localparam logic [2:0] CLS_OFF12  = 3'b010;
  localparam logic [2:0] CLS_SCALED = 3'b011;
  localparam logic [2:0] CLS_LIST   = 3'b100;
  localparam logic [2:0] CLS_BRANCH = 3'b101;
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/shifter_barrel.sv
// shifter_barrel: combinational LSL/LSR/ASR/ROR/RRX with ARM carry-out;
// amount is the effective count (0 = no shift, carry passes through).
module shifter_barrel import shifter_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [8:0]        amount,
  input  logic [1:0]        sh_type,
  input  logic              rrx,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  localparam int LW = $clog2(DATA_W);
  logic [DATA_W:0]     lsl_x, lsr_x, asr_x;
  logic [2*DATA_W-1:0] ror_x;
  // one guard bit beside the data catches the last bit shifted out
  always_comb begin
    lsl_x = {1'b0, data} << amount;
    lsr_x = {data, 1'b0} >> amount;
    asr_x = $unsigned($signed({data, 1'b0}) >>> amount);
    ror_x = {data, data} >> amount[LW-1:0];
    result = rrx ? {cin, data[DATA_W-1:1]} :
             amount == '0 ? data :
             sh_type == LSL ? lsl_x[DATA_W-1:0] :
             sh_type == LSR ? lsr_x[DATA_W:1] :
             sh_type == ASR ? asr_x[DATA_W:1] : ror_x[DATA_W-1:0];
    carry = rrx ? data[0] :
            amount == '0 ? cin :
            sh_type == LSL ? lsl_x[DATA_W] :
            sh_type == LSR ? lsr_x[0] :
            sh_type == ASR ? asr_x[0] : result[DATA_W-1];
  end
endmodule

// File: rtl/shifter_operand_unit.sv
// shifter_operand_unit: shifter-operand/offset generator with valid/ready and registered result.
// Define SHIFTER_REG_SHIFT_EN to enable register-specified (Rs) shifts.
module shifter_operand_unit import shifter_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int SCAN_LANES = 4,
  parameter int BR_ADJ     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic              cin,
  input  logic              enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shifter_operand,
  output logic              cout
);
  localparam int SCAN_STEPS = 16 / SCAN_LANES;
  localparam logic [15:0] LANE_MASK = 16'((17'd1 << SCAN_LANES) - 17'd1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d, b_data, b_res, br_sx, res;
  logic [15:0] list_q, list_d;
  logic [4:0] cnt_q, cnt_d, acc_q, acc_d, acc_sum, imm5;
  logic [8:0] b_amt;
  logic [2:0] cls;
  logic [1:0] sh, b_type;
  logic c_q, c_d, scin_q, scin_d, b_rrx, b_c, res_c;
  logic shift_imm, shift_reg, ext8, use_barrel, scan_cmd, accept;
  logic unused_bits;
  assign cls = ir[27:25];
  assign sh = ir[6:5];
  assign imm5 = ir[11:7];
  assign shift_imm = cls == CLS_SCALED || (cls == CLS_SHIFT && !ir[4]);
`ifdef SHIFTER_REG_SHIFT_EN
  assign shift_reg = cls == CLS_SHIFT && ir[4] && !ir[7];
`else
  assign shift_reg = 1'b0;
`endif
  assign ext8 = cls == CLS_SHIFT && ir[4] && ir[7];
  assign use_barrel = cls == CLS_IMM || shift_imm || shift_reg;
  assign scan_cmd = enable && cls == CLS_LIST;
  assign unused_bits = ^{ir[31:28], ir[24], rs};
  // immediate LSR#0/ASR#0 encode a full-width shift; ROR#0 encodes RRX
  assign b_data = cls == CLS_IMM ? DATA_W'(ir[7:0]) : rm;
  assign b_amt = cls == CLS_IMM ? {4'd0, ir[11:8], 1'b0} :
                 shift_reg ? {1'b0, rs[7:0]} :
                 imm5 == '0 && (sh == LSR || sh == ASR) ? 9'(DATA_W) : {4'd0, imm5};
  assign b_type = cls == CLS_IMM ? ROR : sh;
  assign b_rrx = shift_imm && imm5 == '0 && sh == ROR;
  shifter_barrel #(.DATA_W(DATA_W)) u_barrel (
    .data(b_data), .amount(b_amt), .sh_type(b_type), .rrx(b_rrx), .cin(cin),
    .result(b_res), .carry(b_c)
  );
  assign br_sx = DATA_W'($signed(ir[23:0]));
  assign res = !enable ? rm :
               use_barrel ? b_res :
               ext8 ? DATA_W'({ir[11:8], ir[3:0]}) :
               cls == CLS_OFF12 ? DATA_W'(ir[11:0]) :
               cls == CLS_BRANCH ? (br_sx << 2) + DATA_W'(BR_ADJ) : rm;
  assign res_c = enable && use_barrel ? b_c : cin;
  assign in_ready = rst_n && state_q != SCAN && (state_q != HOLD || out_ready);
  assign out_valid = state_q == HOLD;
  assign shifter_operand = op_q;
  assign cout = c_q;
  assign accept = in_valid && in_ready;
  assign acc_sum = acc_q + popcount16(list_q & LANE_MASK);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    c_d = c_q;
    list_d = list_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    scin_d = scin_q;
    if (state_q == SCAN) begin
      list_d = list_q >> SCAN_LANES;
      cnt_d = cnt_q + 5'd1;
      acc_d = acc_sum;
      if (cnt_q == 5'(SCAN_STEPS - 1)) begin
        state_d = HOLD;
        op_d = DATA_W'({acc_sum, 2'b00});
        c_d = scin_q;
      end
    end else if (accept && scan_cmd) begin
      state_d = SCAN;
      list_d = ir[15:0];
      cnt_d = '0;
      acc_d = '0;
      scin_d = cin;
    end else if (accept) begin
      state_d = HOLD;
      op_d = res;
      c_d = res_c;
    end else if (out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      c_q <= 1'b0;
      list_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      scin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      c_q <= c_d;
      list_q <= list_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      scin_q <= scin_d;
    end
  end
endmodule

// File: tb/tb_shifter_operand_unit.sv
// tb_shifter_operand_unit: directed and random commands checked against a behavioural model.
// Model follows SHIFTER_REG_SHIFT_EN the same way as the build.
module tb_shifter_operand_unit;
  logic clk = 0, rst_n = 1, in_valid = 0, in_ready, out_ready = 1, cin = 0, enable = 1;
  logic out_valid, cout;
  logic [31:0] ir = 0, rm = 0, rs = 0, shifter_operand;
  int n_checks = 0, n_pass = 0;

  shifter_operand_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ir(ir), .rm(rm),
    .rs(rs), .cin(cin), .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .shifter_operand(shifter_operand), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    int m = n % 32;
    return m == 0 ? x : (x >> m) | (x << (32 - m));
  endfunction

  task automatic shift_ref(input logic [1:0] sh, input logic [31:0] x, input int n,
                           input logic ci, output logic [31:0] r, output logic c);
    if (n == 0) begin r = x; c = ci; end
    else case (sh)
      2'd0: if (n < 32) begin r = x << n; c = x[5'(32 - n)]; end
            else begin r = 0; c = n == 32 ? x[0] : 1'b0; end
      2'd1: if (n < 32) begin r = x >> n; c = x[5'(n - 1)]; end
            else begin r = 0; c = n == 32 ? x[31] : 1'b0; end
      2'd2: if (n < 32) begin r = 32'($signed(x) >>> n); c = x[5'(n - 1)]; end
            else begin r = {32{x[31]}}; c = x[31]; end
      default: begin r = ror32(x, n); c = n % 32 == 0 ? x[31] : x[5'(n % 32 - 1)]; end
    endcase
  endtask

  task automatic model(input logic [31:0] i_ir, i_rm, i_rs, input logic i_cin, i_en,
                       output logic [31:0] r, output logic c);
    logic [2:0] cls = i_ir[27:25];
    logic [1:0] sh = i_ir[6:5];
    int n = int'(i_ir[11:7]);
    int s;
    r = i_rm;
    c = i_cin;
    if (!i_en) return;
    if (cls == 3'b001) begin
      n = 2 * int'(i_ir[11:8]);
      r = ror32({24'd0, i_ir[7:0]}, n);
      c = n == 0 ? i_cin : r[31];
    end else if (cls == 3'b011 || (cls == 3'b000 && !i_ir[4])) begin
      if (n == 0 && sh == 2'd1) begin r = 0; c = i_rm[31]; end
      else if (n == 0 && sh == 2'd2) begin r = {32{i_rm[31]}}; c = i_rm[31]; end
      else if (n == 0 && sh == 2'd3) begin r = {i_cin, i_rm[31:1]}; c = i_rm[0]; end
      else shift_ref(sh, i_rm, n, i_cin, r, c);
    end else if (cls == 3'b000 && i_ir[7]) begin
      r = {24'd0, i_ir[11:8], i_ir[3:0]};
    end else if (cls == 3'b000) begin
`ifdef SHIFTER_REG_SHIFT_EN
      shift_ref(sh, i_rm, int'(i_rs[7:0]), i_cin, r, c);
`endif
    end else if (cls == 3'b010) begin
      r = {20'd0, i_ir[11:0]};
    end else if (cls == 3'b100) begin
      r = 32'(4 * $countones(i_ir[15:0]));
    end else if (cls == 3'b101) begin
      s = int'($signed(i_ir[23:0]));
      r = 32'(s * 4 + 4);
    end
  endtask

  task automatic run_op(input logic [31:0] i_ir, i_rm, i_rs, input logic i_cin, i_en);
    logic [31:0] er;
    logic ec;
    int lat = 1;
    bit scan = i_en && i_ir[27:25] == 3'b100;
    model(i_ir, i_rm, i_rs, i_cin, i_en, er, ec);
    ir = i_ir; rm = i_rm; rs = i_rs; cin = i_cin; enable = i_en; in_valid = 1;
    check("ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; ir = $urandom; rm = $urandom; rs = $urandom; cin = 1'($urandom); enable = 1'($urandom);
    while (!out_valid && lat < 20) begin
      check("in_ready_scan", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, scan ? 5 : 1);
    check("operand", shifter_operand, er);
    check("carry", cout, ec);
  endtask

  initial begin
    logic [31:0] er, r_ir, r_rs;
    logic ec;
    int seen;
    #1 rst_n = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_operand", shifter_operand, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("idle_ready", in_ready, 1);

    run_op(32'h0000_0000, 32'h8000_0001, 0, 1, 1);
    run_op(32'h0000_0000, 32'h8000_0001, 0, 0, 1);
    run_op(32'h0200_04FF, 32'h1234_5678, 0, 0, 1);
    run_op(32'h0200_00FF, 32'h1234_5678, 0, 1, 1);
    run_op(32'h0000_0060, 32'h0000_0003, 0, 1, 1);
    run_op(32'h0000_0020, 32'h8000_0000, 0, 0, 1);
    run_op(32'h0000_0040, 32'h8000_0010, 0, 0, 1);
    run_op(32'h0000_0010, 32'h0000_0001, 32, 0, 1);
    run_op(32'h0000_0010, 32'h0000_0001, 33, 1, 1);
    run_op(32'h0000_0070, 32'h8000_0005, 64, 0, 1);
    run_op(32'h0000_0050, 32'h8000_0005, 40, 0, 1);
    run_op(32'h0000_0F9F, 32'h1111_1111, 0, 1, 1);
    run_op(32'h0400_0ABC, 32'h1111_1111, 0, 0, 1);
    run_op(32'h0800_FFFF, 32'h1111_1111, 0, 1, 1);
    run_op(32'h0800_0000, 32'h1111_1111, 0, 0, 1);
    run_op(32'h0800_8421, 32'h1111_1111, 0, 1, 1);
    run_op(32'h0A00_0001, 32'h1111_1111, 0, 0, 1);
    run_op(32'h0AFF_FFFF, 32'h1111_1111, 0, 1, 1);
    run_op(32'h0E00_0000, 32'hCAFE_F00D, 0, 1, 1);
    run_op(32'h0A00_0001, 32'hDEAD_BEEF, 0, 1, 0);
    run_op(32'h0800_FFFF, 32'hDEAD_BEEF, 0, 0, 0);

    for (int k = 0; k < 300; k++) begin
      r_ir = $urandom;
      r_ir[27:25] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r_ir[11:7] = 0;
      if ($urandom_range(0, 3) == 0) begin r_ir[27:25] = 0; r_ir[4] = 1; r_ir[7] = 0; end
      case ($urandom_range(0, 8))
        0: r_rs = 0;  1: r_rs = 1;  2: r_rs = 31;  3: r_rs = 32;  4: r_rs = 33;
        5: r_rs = 64; 6: r_rs = 255; 7: r_rs = 32'h100; default: r_rs = $urandom;
      endcase
      run_op(r_ir, $urandom, r_rs, 1'($urandom), $urandom_range(0, 7) != 0);
    end

    for (int k = 0; k < 6; k++) begin
      ir = $urandom; rm = $urandom; rs = $urandom_range(0, 40); cin = 1'($urandom); enable = 1'($urandom);
      if (enable && ir[27:25] == 3'b100) ir[27:25] = 3'b101;
      model(ir, rm, rs, cin, enable, er, ec);
      in_valid = 1;
      check("b2b_ready", in_ready, 1);
      @(posedge clk); #1;
      check("b2b_valid", out_valid, 1);
      check("b2b_operand", shifter_operand, er);
      check("b2b_carry", cout, ec);
    end
    in_valid = 0;
    @(posedge clk); #1;
    check("b2b_drain", out_valid, 0);

    out_ready = 0;
    ir = 32'h0000_0060; rm = 32'h0000_0003; rs = 0; cin = 1; enable = 1; in_valid = 1;
    model(ir, rm, rs, cin, enable, er, ec);
    @(posedge clk); #1;
    in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      ir = $urandom; rm = $urandom; cin = 1'($urandom);
      check("hold_valid", out_valid, 1);
      check("hold_operand", shifter_operand, er);
      check("hold_carry", cout, ec);
      check("hold_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    #1 check("release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("release_valid", out_valid, 0);

    ir = 32'h0800_FFFF; enable = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("scan_rst_valid", out_valid, 0);
    check("scan_rst_ready", in_ready, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("scan_rst_no_result", seen, 0);
    check("scan_rst_idle_ready", in_ready, 1);

    out_ready = 0;
    ir = 32'h0400_0123; enable = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("hold2_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("hold_rst_valid", out_valid, 0);
    check("hold_rst_operand", shifter_operand, 0);
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    check("hold_rst_idle", out_valid, 0);
    run_op(32'h0000_0028, 32'hF000_000F, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
